kogge_stone_wide_seq: RTL and testbench

- Multi-cycle wide-operand adder sequencer built around one 16-bit Kogge-Stone adder core (A, B, cin in; sum, cout out).
- Accepts a WORDS×16-bit operand pair over a valid/ready handshake.
- Feeds the core one 16-bit slice per cycle, LSB slice first, and chains each slice's cout into the next slice's cin.
- Returns the full sum, carry-out and signed overflow over a second valid/ready handshake.

---
 rtl/kogge_stone_wide_seq.sv | 165 ++++++++++++++++
 tb/tb_kogge_stone_wide_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/kogge_stone_wide_seq.sv
// rtl/kogge_stone_wide_seq.sv - multi-cycle wide adder sequencer around a 16-bit Kogge-Stone core
//
// kogge_stone_wide_seq: adds two WORDS*16-bit operands one 16-bit slice per
// cycle (LSB slice first), chaining each slice's carry into the next slice.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin [, sub])
//   out_valid/out_ready : result handshake (sum, cout, ovf)
// Optional macro KS_WIDE_SUB_EN adds input 'sub' selecting a - b.
//
// kogge_stone16: combinational 16-bit Kogge-Stone adder.
//   i_a, i_b, i_cin -> o_sum, o_cout

module kogge_stone16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_p0;

  assign w_p0 = i_a ^ i_b;

  always_comb begin : prefix
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_gn;
    logic [15:0] w_pn;
    w_g = i_a & i_b;
    w_p = w_p0;
    // Fold the carry-in into bit 0 so every group generate already includes it.
    w_g[0] = w_g[0] | (w_p[0] & i_cin);
    for (int lvl = 0; lvl < 4; lvl++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = (1 << lvl); i < 16; i++) begin
        w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lvl)]);
        w_pn[i] = w_p[i] & w_p[i - (1 << lvl)];
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    // Carry into bit i is the group generate of bits [i-1:0].
    o_sum  = w_p0 ^ {w_g[14:0], i_cin};
    o_cout = w_g[15];
  end
endmodule

module kogge_stone_wide_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
`ifdef KS_WIDE_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_sub;
  logic          w_sub_in;
  logic          w_last;
  logic [15:0]   w_core_b;
  logic [15:0]   w_core_sum;
  logic          w_core_cout;

`ifdef KS_WIDE_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  assign w_last   = (r_idx == IW'(WORDS - 1));
  // Subtraction is a + ~b + 1: invert the B slices, the +1 comes from the carry seed.
  assign w_core_b = r_b[16*r_idx +: 16] ^ {16{r_sub}};

  kogge_stone16 u_core (
    .i_a    (r_a[16*r_idx +: 16]),
    .i_b    (w_core_b),
    .i_cin  (r_carry),
    .o_sum  (w_core_sum),
    .o_cout (w_core_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= w_sub_in;
            r_carry <= w_sub_in ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[16*r_idx +: 16] <= w_core_sum;
          r_carry <= w_core_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout <= w_core_cout;
            r_ovf  <= r_a[W-1] ^ r_b[W-1] ^ r_sub ^ w_core_sum[15] ^ w_core_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_kogge_stone_wide_seq.sv
// tb/tb_kogge_stone_wide_seq.sv - directed self-checking bench for kogge_stone_wide_seq
module tb_kogge_stone_wide_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
`ifdef KS_WIDE_SUB_EN
  logic        sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  kogge_stone_wide_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef KS_WIDE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair; returns after the accepting edge (+1).
  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic cv, input logic sv);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    check("send_ready", {63'd0, in_ready}, 64'd1);
    a = av; b = bv; cin = cv;
`ifdef KS_WIDE_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub ignored in add-only build");
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin tick(); edges++; end
    check("done_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [63:0] av, input logic [63:0] bv, input logic cv,
                    input logic sv, input logic [63:0] es, input logic ec, input logic eo);
    int e;
    send(av, bv, cv, sv);
    wait_done(e);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
    consume();
  endtask

  initial begin
    int e;
    int acc;
    logic [63:0] held;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
`ifdef KS_WIDE_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);

    // Carry ripple with latency measurement.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_done(e);
    check("ripple_latency", 64'(e), 64'd4);
    check("ripple_sum", sum, 64'd0);
    check("ripple_cout", {63'd0, cout}, 64'd1);
    check("ripple_ovf", {63'd0, ovf}, 64'd0);

    // Backpressure: hold for 10 cycles.
    held = sum;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_sum", sum, held);
      check("bp_cout", {63'd0, cout}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    consume();
    check("bp_release_ready", {63'd0, in_ready}, 64'd1);
    check("bp_release_valid", {63'd0, out_valid}, 64'd0);

    op("povf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op("novf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
    op("mix", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
       64'h2222_2222_2222_2212, 1'b0, 1'b0);

    // Busy rejection: in_valid held high across the whole operation.
    a = 64'd3; b = 64'd4; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_valid && in_ready) acc++;
      tick();
    end
    check("busy_accepts", 64'(acc), 64'd1);
    check("busy_valid", {63'd0, out_valid}, 64'd1);
    check("busy_sum1", sum, 64'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (in_valid && in_ready) acc++;
    tick();
    in_valid = 1'b0;
    check("busy_second_accept", 64'(acc), 64'd2);
    wait_done(e);
    check("busy_sum2", sum, 64'd7);
    consume();

    // Reset mid-RUN at idx==2.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_sum", sum, 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_no_valid", {63'd0, out_valid}, 64'd0);
    end
    op("fresh", 64'd1, 64'd2, 1'b1, 1'b0, 64'd4, 1'b0, 1'b0);

`ifdef KS_WIDE_SUB_EN
    op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    op("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
